// File: rtl/mem_stage_pkg.sv
// Shared types and codes for the memory stage and its load aligner.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
    localparam logic [1:0] EXC_SIZE     = 2'b11;

    function automatic logic [3:0] byte_en(
        input logic [1:0] sz,
        input logic [1:0] off
    );
        logic [3:0] be;
        case (sz)
            SZ_B:    be = 4'b0001 << off;
            SZ_H:    be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic misaligned(
        input logic [1:0] sz,
        input logic [1:0] off
    );
        logic m;
        case (sz)
            SZ_H:    m = off[0];
            SZ_W:    m = (off != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Lane select and sign/zero extension of a 32-bit read word.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_B:    data = {{24{b[7] & ~is_unsigned}}, b};
            SZ_H:    data = {{16{h[15] & ~is_unsigned}}, h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: ALU passthrough, one outstanding load/store with timeout.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] alu_res,
    input  logic [31:0] B_res,
    input  logic [31:0] PC_res,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [4:0]  rd,
    input  logic        reg_wr,
    output logic        ex_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_we,
    output logic [31:0] wb_pc,
    output logic        exc_valid,
    output logic [1:0]  exc_cause
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [4:0]  rd_q, rd_d;
    logic        regwr_q, regwr_d;
    logic [31:0] pc_q, pc_d;
    logic        wbv_q, wbv_d;
    logic [31:0] wbd_q, wbd_d;
    logic [4:0]  wbr_q, wbr_d;
    logic        wbw_q, wbw_d;
    logic [31:0] wbp_q, wbp_d;
    logic        excv_q, excv_d;
    logic [1:0]  excc_q, excc_d;
    logic [31:0] ld_data;

    load_align u_align (
        .rdata       (dmem_rdata),
        .off         (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (ld_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rd_d    = rd_q;
        regwr_d = regwr_q;
        pc_d    = pc_q;
        wbv_d   = 1'b0;
        wbd_d   = wbd_q;
        wbr_d   = wbr_q;
        wbw_d   = 1'b0;
        wbp_d   = wbp_q;
        excv_d  = 1'b0;
        excc_d  = excc_q;
        case (state_q)
            IDLE: begin
                if (ex_valid && !(mem_rd || mem_wr)) begin
                    wbv_d = 1'b1;
                    wbd_d = alu_res;
                    wbr_d = rd;
                    wbw_d = reg_wr;
                    wbp_d = PC_res;
                end else if (ex_valid) begin
                    wbp_d = PC_res;
                    if (mem_size == 2'b11) begin
                        excv_d = 1'b1;
                        excc_d = EXC_SIZE;
                    end else if (misaligned(mem_size, alu_res[1:0])) begin
                        excv_d = 1'b1;
                        excc_d = EXC_MISALIGN;
                    end else begin
                        state_d = REQ;
                        cnt_d   = '0;
                        addr_d  = alu_res;
                        be_d    = byte_en(mem_size, alu_res[1:0]);
                        we_d    = mem_wr;
                        size_d  = mem_size;
                        uns_d   = mem_unsigned;
                        rd_d    = rd;
                        regwr_d = reg_wr & ~mem_wr;
                        pc_d    = PC_res;
                        case (mem_size)
                            SZ_B:    wdata_d = {4{B_res[7:0]}};
                            SZ_H:    wdata_d = {2{B_res[15:0]}};
                            default: wdata_d = B_res;
                        endcase
                    end
                end
            end
            REQ: begin
                // ack takes priority over the timeout on the final cycle
                if (dmem_ack) begin
                    state_d = DONE;
                    wbv_d   = 1'b1;
                    wbd_d   = we_q ? 32'h0 : ld_data;
                    wbr_d   = rd_q;
                    wbw_d   = regwr_q;
                    wbp_d   = pc_q;
                end else if (int'(cnt_q) >= ACK_TIMEOUT - 1) begin
                    state_d = IDLE;
                    excv_d  = 1'b1;
                    excc_d  = EXC_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            rd_q    <= '0;
            regwr_q <= 1'b0;
            pc_q    <= '0;
            wbv_q   <= 1'b0;
            wbd_q   <= '0;
            wbr_q   <= '0;
            wbw_q   <= 1'b0;
            wbp_q   <= '0;
            excv_q  <= 1'b0;
            excc_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rd_q    <= rd_d;
            regwr_q <= regwr_d;
            pc_q    <= pc_d;
            wbv_q   <= wbv_d;
            wbd_q   <= wbd_d;
            wbr_q   <= wbr_d;
            wbw_q   <= wbw_d;
            wbp_q   <= wbp_d;
            excv_q  <= excv_d;
            excc_q  <= excc_d;
        end
    end

    assign ex_stall   = (state_q != IDLE);
    assign dmem_req   = (state_q == REQ);
    assign dmem_we    = dmem_req & we_q;
    assign dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign wb_valid   = wbv_q;
    assign wb_data    = wbd_q;
    assign wb_rd      = wbr_q;
    assign wb_we      = wbw_q;
    assign wb_pc      = wbp_q;
    assign exc_valid  = excv_q;
    assign exc_cause  = excc_q;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15, sets the maximum cycles the block waits for dmem_ack before it aborts with a bus error.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 ex_valid  input  1  EX stage presents a valid instruction result this cycle.
REQ-005 alu_res  input  32  ALU result; the effective address for loads and stores.
REQ-006 B_res  input  32  store data, taken from operand B.
REQ-007 PC_res  input  32  PC of the instruction.
REQ-008 mem_rd, mem_wr  input  1 each  load or store request; both high together is illegal and SHALL be treated as a store.
REQ-009 mem_size  input  2  access size: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-010 mem_unsigned  input  1  zero-extend load data when high, sign-extend when low.
REQ-011 rd  input  5  destination register; reg_wr  input  1  writeback enable.
REQ-012 ex_stall  output  1  backpressure to EX; EX SHALL hold its outputs while this is high.
REQ-013 dmem_req  output  1; dmem_we  output  1; dmem_addr  output  32; dmem_wdata  output  32; dmem_be  output  4  data-memory request bundle.
REQ-014 dmem_ack  input  1; dmem_rdata  input  32  memory response.
REQ-015 wb_valid  output  1; wb_data  output  32; wb_rd  output  5; wb_we  output  1; wb_pc  output  32  writeback bundle.
REQ-016 exc_valid  output  1; exc_cause  output  2  exception flag and cause: 01 misaligned, 10 bus timeout, 11 illegal size.

Function
REQ-017 The FSM states SHALL be IDLE, REQ, DONE.
REQ-018 IDLE: ex_valid with a non-memory op SHALL register the result and assert wb_valid the next cycle with wb_data=alu_res and wb_we=reg_wr; latency is 1.
REQ-019 IDLE: ex_valid with a legal, aligned memory op SHALL capture the address, data and size, then move to REQ with ex_stall high.
REQ-020 REQ: dmem_req SHALL stay high with a stable bundle until dmem_ack; on ack the FSM SHALL move to DONE.
REQ-021 DONE: the FSM SHALL pulse wb_valid for one cycle and return to IDLE.
REQ-022 Load-to-wb_valid latency SHALL be the ack cycle + 1; the minimum is 2 cycles after capture.
REQ-023 The FSM SHALL accept no new ex_valid while in REQ or DONE, and ex_stall SHALL be high in those states.
REQ-024 Stores SHALL replicate the data across lanes: a byte store drives {4{B[7:0]}} and a half store drives {2{B[15:0]}}.
REQ-025 dmem_be SHALL be 0001<<addr[1:0] for byte, 0011<<(addr[1]*2) for half, and 1111 for word; dmem_addr SHALL be {addr[31:2],2'b00}.
REQ-026 Loads SHALL select the lane from the captured addr[1:0], then extend per mem_unsigned; a store SHALL write back nothing (wb_we=0).
REQ-027 A misaligned access (half with addr[0]=1, or word with addr[1:0]≠0) SHALL issue no request and SHALL pulse exc_valid with cause 01 the next cycle, with wb_we=0.
REQ-028 mem_size=11 on a memory op SHALL likewise issue no request and pulse cause 11.
REQ-029 A timeout counter SHALL clear on entry to REQ; if it reaches ACK_TIMEOUT without ack, the FSM SHALL drop dmem_req, pulse exc_valid with cause 10 and return to IDLE.
REQ-030 If ack arrives in the same cycle the counter reaches ACK_TIMEOUT, the ack SHALL win.
REQ-031 dmem_ack while in IDLE or DONE SHALL be ignored.

Reset
REQ-032 rst SHALL force state IDLE and zero every output, counter and captured register, regardless of clk.
REQ-033 Assertion of rst during REQ SHALL drop dmem_req immediately, and the block SHALL produce no wb_valid for the aborted access.

Structure
REQ-034 A shared package SHALL hold the state enum, the size codes (SZ_B, SZ_H, SZ_W), and the exception cause codes.
REQ-035 A combinational sub-module load_align SHALL perform lane select and extension, and SHALL be reusable by the fetch path.

Verification
REQ-036 ALU op with alu_res=0x1234, rd=5, reg_wr=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, no dmem_req.
REQ-037 Byte store of B=0xAABBCCDD at addr 0x103 -> dmem_be=1000, dmem_wdata=0xDDDDDDDD, dmem_addr=0x100, wb_we=0.
REQ-038 Signed byte load at 0x102 with rdata=0x0080_0000 and ack after 3 cycles -> wb_data=0xFFFFFF80 one cycle after ack, ex_stall high throughout.
REQ-039 Word load at 0x202 -> no dmem_req, exc_valid=1 with cause 01 the next cycle.
REQ-040 Word load never acked, ACK_TIMEOUT=15 -> dmem_req high for 15 cycles, then cause 10 and the FSM back in IDLE.
REQ-041 rst pulsed two cycles into REQ -> all outputs 0 asynchronously; no wb_valid after rst is released.
